// File: rtl/regfile_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_write_ctrl_if
// Bundle of the writeback request, flush control and register-file write
// signals shared between the write-port controller and its surroundings.
//
//   v0/a0/d0, v1/a1/d1 : requester valid, destination address, write data
//   rdy0/rdy1          : per-requester accept strobes (combinational)
//   flush              : start a zeroing sweep of all registers
//   busy               : high while the sweep is running
//   flush_done         : pulse alongside the final sweep write
//   load_vec           : one-hot LOAD enables to the register flops
//   wr_data            : shared D bus to the register flops
//
// Modports: master = requesters/environment, slave = controller.
// ---------------------------------------------------------------------------
interface regfile_write_ctrl_if #(
  parameter int NREG = 8,
  parameter int AW   = 3
);
  logic            v0;
  logic [AW-1:0]   a0;
  logic [15:0]     d0;
  logic            rdy0;
  logic            v1;
  logic [AW-1:0]   a1;
  logic [15:0]     d1;
  logic            rdy1;
  logic            flush;
  logic            busy;
  logic            flush_done;
  logic [NREG-1:0] load_vec;
  logic [15:0]     wr_data;

  modport master (
    output v0, a0, d0, v1, a1, d1, flush,
    input  rdy0, rdy1, busy, flush_done, load_vec, wr_data
  );

  modport slave (
    input  v0, a0, d0, v1, a1, d1, flush,
    output rdy0, rdy1, busy, flush_done, load_vec, wr_data
  );
endinterface

// File: rtl/regfile_write_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_write_ctrl
// Write-port controller for the CPU register file. Arbitrates round-robin
// between the ALU (requester 0) and the load unit (requester 1), and drives a
// registered one-hot LOAD vector plus a shared 16-bit data bus into the
// register flops. A flush request runs a sweep that zeroes every register,
// one register per cycle.
//
// Ports:
//   clk  : clock, rising edge
//   clr  : synchronous active-high reset
//   bus  : regfile_write_ctrl_if.slave (requests, flush, load_vec, wr_data)
//
// Parameters:
//   NREG    : number of registers driven
//   AW      : register address width (clog2(NREG))
//   ZERO_R0 : 1 = writes to register 0 are acknowledged but not loaded
// ---------------------------------------------------------------------------
module regfile_write_ctrl #(
  parameter int NREG    = 8,
  parameter int AW      = 3,
  parameter int ZERO_R0 = 1
) (
  input  logic                 clk,
  input  logic                 clr,
  regfile_write_ctrl_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   idx_q;
  logic            last_grant_q;
  logic [NREG-1:0] load_vec_q;
  logic [15:0]     wr_data_q;
  logic            flush_done_q;

  // Arbitration is open only in IDLE with no flush starting and no reset,
  // so a request can never be accepted on the cycle a flush begins.
  logic arb_open;
  logic grant0;
  logic grant1;
  logic accept;

  assign arb_open = (state_q == IDLE) && !clr && !bus.flush;
  // On a tie the requester that did not win last time goes first.
  assign grant0   = arb_open && bus.v0 && (!bus.v1 || last_grant_q);
  assign grant1   = arb_open && bus.v1 && (!bus.v0 || !last_grant_q);
  assign accept   = grant0 || grant1;

  logic [AW-1:0] win_addr;
  logic [15:0]   win_data;
  logic          drop_r0;

  assign win_addr = grant0 ? bus.a0 : bus.a1;
  assign win_data = grant0 ? bus.d0 : bus.d1;
  assign drop_r0  = (ZERO_R0 != 0) && (win_addr == '0);

  // Address decoders for the winning write and for the sweep index.
  logic [NREG-1:0] win_onehot;
  logic [NREG-1:0] idx_onehot;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
      assign win_onehot[gi] = (win_addr == AW'(gi));
      assign idx_onehot[gi] = (idx_q == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      last_grant_q <= 1'b1;
      load_vec_q   <= '0;
      wr_data_q    <= '0;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          flush_done_q <= 1'b0;
          if (bus.flush) begin
            state_q    <= FLUSH;
            idx_q      <= '0;
            load_vec_q <= '0;
          end else if (accept) begin
            wr_data_q    <= win_data;
            load_vec_q   <= drop_r0 ? '0 : win_onehot;
            last_grant_q <= grant1;
          end else begin
            load_vec_q <= '0;
          end
        end
        FLUSH: begin
          // Register 0 is swept too, whatever ZERO_R0 says.
          load_vec_q <= idx_onehot;
          wr_data_q  <= '0;
          if (idx_q == AW'(NREG - 1)) begin
            flush_done_q <= 1'b1;
            state_q      <= IDLE;
            idx_q        <= '0;
          end else begin
            flush_done_q <= 1'b0;
            idx_q        <= idx_q + AW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rdy0       = grant0;
  assign bus.rdy1       = grant1;
  assign bus.busy       = (state_q == FLUSH);
  assign bus.flush_done = flush_done_q;
  assign bus.load_vec   = load_vec_q;
  assign bus.wr_data    = wr_data_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_ctrl
// Table of per-cycle vectors: each record holds the inputs driven during one
// cycle and the outputs expected in that same cycle (combinational rdy plus
// registered load_vec/wr_data/busy/flush_done produced by the previous edge).
// A hand-written sequence afterwards measures a full flush with a bounded wait.
// ---------------------------------------------------------------------------
module tb_regfile_write_ctrl;

  localparam int NREG = 8;
  localparam int AW   = 3;

  logic clk;
  logic clr;

  regfile_write_ctrl_if #(.NREG(NREG), .AW(AW)) bus ();

  regfile_write_ctrl #(.NREG(NREG), .AW(AW), .ZERO_R0(1)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          clr;
    logic          v0;
    logic [AW-1:0] a0;
    logic [15:0]   d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [15:0]   d1;
    logic          flush;
    logic          rdy0;
    logic          rdy1;
    logic [7:0]    lv;
    logic [15:0]   wd;
    logic          busy;
    logic          fd;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  function automatic vec_t mk(
    input logic clr_i, input logic v0_i, input logic [AW-1:0] a0_i, input logic [15:0] d0_i,
    input logic v1_i, input logic [AW-1:0] a1_i, input logic [15:0] d1_i, input logic flush_i,
    input logic r0, input logic r1, input logic [7:0] lv, input logic [15:0] wd,
    input logic busy, input logic fd);
    vec_t v;
    v.clr = clr_i; v.v0 = v0_i; v.a0 = a0_i; v.d0 = d0_i;
    v.v1 = v1_i; v.a1 = a1_i; v.d1 = d1_i; v.flush = flush_i;
    v.rdy0 = r0; v.rdy1 = r1; v.lv = lv; v.wd = wd; v.busy = busy; v.fd = fd;
    return v;
  endfunction

  function automatic logic [7:0] walk(input int k);
    logic [7:0] one;
    one = 8'h01;
    return (k == 0) ? 8'h00 : (one << (k - 1));
  endfunction

  task automatic drive(input vec_t v);
    clr       = v.clr;
    bus.v0    = v.v0;
    bus.a0    = v.a0;
    bus.d0    = v.d0;
    bus.v1    = v.v1;
    bus.a1    = v.a1;
    bus.d1    = v.d1;
    bus.flush = v.flush;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    logic ok;
    ok = (bus.rdy0 === v.rdy0) && (bus.rdy1 === v.rdy1) && (bus.load_vec === v.lv) &&
         (bus.wr_data === v.wd) && (bus.busy === v.busy) && (bus.flush_done === v.fd) &&
         ($countones(bus.load_vec) <= 1);
    total_cnt++;
    if (ok) begin
      pass_cnt++;
      $display("vec %0d: rdy=%b%b load_vec=%02h wr_data=%04h busy=%b done=%b ok",
               idx, bus.rdy0, bus.rdy1, bus.load_vec, bus.wr_data, bus.busy, bus.flush_done);
    end else begin
      $display("FAIL vec %0d: got rdy=%b%b load_vec=%02h wr_data=%04h busy=%b done=%b, want rdy=%b%b load_vec=%02h wr_data=%04h busy=%b done=%b",
               idx, bus.rdy0, bus.rdy1, bus.load_vec, bus.wr_data, bus.busy, bus.flush_done,
               v.rdy0, v.rdy1, v.lv, v.wd, v.busy, v.fd);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    total_cnt++;
    if (got == want) begin
      pass_cnt++;
      $display("%s: got %0d ok", name, got);
    end else begin
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  initial begin
    // ---- vector table ----
    //            clr v0 a0 d0       v1 a1 d1       fl  r0 r1 lv     wd       bsy fd
    // reset state, rdy forced low under clr
    vecs.push_back(mk(1, 1, 3, 16'hBEEF, 0, 0, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0, 0));
    // single write to R3
    vecs.push_back(mk(0, 1, 3, 16'hBEEF, 0, 0, 16'h0000, 0,  1, 0, 8'h00, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h08, 16'hBEEF, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h00, 16'hBEEF, 0, 0));
    // contention; requester 0 won last, so requester 1 goes first
    vecs.push_back(mk(0, 1, 1, 16'h1111, 1, 2, 16'h2222, 0,  0, 1, 8'h00, 16'hBEEF, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h1111, 1, 2, 16'h2222, 0,  1, 0, 8'h04, 16'h2222, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h1111, 1, 2, 16'h2222, 0,  0, 1, 8'h02, 16'h1111, 0, 0));
    vecs.push_back(mk(0, 1, 1, 16'h1111, 1, 2, 16'h2222, 0,  1, 0, 8'h04, 16'h2222, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h02, 16'h1111, 0, 0));
    // R0 write dropped but acknowledged, data still updates
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 0, 16'h1234, 0,  0, 1, 8'h00, 16'h1111, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h00, 16'h1234, 0, 0));
    // flush with concurrent v0
    vecs.push_back(mk(0, 1, 5, 16'h5555, 0, 0, 16'h0000, 1,  0, 0, 8'h00, 16'h1234, 0, 0));
    for (int k = 0; k < NREG; k++)
      vecs.push_back(mk(0, 1, 5, 16'h5555, 0, 0, 16'h0000, (k == 2) ? 1'b1 : 1'b0,
                        0, 0, walk(k), (k == 0) ? 16'h1234 : 16'h0000, 1, 0));
    vecs.push_back(mk(0, 1, 5, 16'h5555, 0, 0, 16'h0000, 0,  1, 0, 8'h80, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h20, 16'h5555, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h00, 16'h5555, 0, 0));
    // reset during the 4th flush cycle
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 8'h00, 16'h5555, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h00, 16'h5555, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h01, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h02, 16'h0000, 1, 0));
    vecs.push_back(mk(1, 1, 6, 16'h6666, 1, 7, 16'h7777, 0,  0, 0, 8'h04, 16'h0000, 1, 0));
    // tie after reset grants requester 0
    vecs.push_back(mk(0, 1, 6, 16'h6666, 1, 7, 16'h7777, 0,  1, 0, 8'h00, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h40, 16'h6666, 0, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h00, 16'h6666, 0, 0));
    // flush held high: sweep, done, immediate second sweep
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 8'h00, 16'h6666, 0, 0));
    for (int k = 0; k < NREG; k++)
      vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,
                        0, 0, walk(k), (k == 0) ? 16'h6666 : 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 8'h80, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 8'h00, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 0, 8'h01, 16'h0000, 1, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h02, 16'h0000, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 0, 8'h00, 16'h0000, 0, 0));

    // ---- preamble: one reset edge so registered outputs are defined ----
    clr = 1'b1;
    bus.v0 = 0; bus.a0 = '0; bus.d0 = '0;
    bus.v1 = 0; bus.a1 = '0; bus.d1 = '0;
    bus.flush = 0;
    @(posedge clk);

    // ---- table: drive after the falling edge, sample 1 time unit later ----
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_vec(i, vecs[i]);
    end

    // ---- hand sequence: single flush pulse, bounded wait for flush_done ----
    begin
      int busy_cycles;
      int done_seen;
      logic [7:0]  last_lv;
      logic [15:0] last_wd;
      busy_cycles = 0;
      done_seen   = 0;
      last_lv     = '0;
      last_wd     = '1;
      @(negedge clk);
      clr = 1'b0;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      for (int c = 0; c < 40 && done_seen == 0; c++) begin
        #1;
        if (bus.busy === 1'b1) busy_cycles++;
        if (bus.flush_done === 1'b1) begin
          done_seen = 1;
          last_lv   = bus.load_vec;
          last_wd   = bus.wr_data;
        end
        @(negedge clk);
      end
      check_val("flush_done_seen", done_seen, 1);
      check_val("flush_busy_cycles", busy_cycles, NREG);
      check_val("flush_last_load_vec", int'(last_lv), 8'h80);
      check_val("flush_last_wr_data", int'(last_wd), 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the bank of 16-bit `LOAD`/`clr` registers that forms the CPU register file. It arbitrates round-robin between two writeback requesters (ALU result and load/memory result) and drives a registered one-hot `LOAD` vector plus a shared 16-bit data bus into the register flops. It also runs a sequenced flush that zeroes every register, one register per cycle.

## Interface
- `NREG`, default 8: number of 16-bit registers driven.
- `AW`, default 3: register address width; equals clog2(`NREG`).
- `ZERO_R0`, default 1: when 1, writes to register 0 are accepted but dropped (R0 reads as constant zero).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `v0`  in  1  requester 0 (ALU) write valid.
- `a0`  in  AW  requester 0 destination register.
- `d0`  in  16  requester 0 write data.
- `rdy0`  out  1  requester 0 accepted this cycle; combinational.
- `v1`  in  1  requester 1 (load unit) write valid.
- `a1`  in  AW  requester 1 destination register.
- `d1`  in  16  requester 1 write data.
- `rdy1`  out  1  requester 1 accepted this cycle; combinational.
- `flush`  in  1  start a zeroing sweep of all registers (one-cycle pulse or level).
- `busy`  out  1  high while in FLUSH state.
- `flush_done`  out  1  one-cycle pulse, coincident with the final flush write.
- `load_vec`  out  NREG  one-hot `LOAD` enables to the register flops; registered.
- `wr_data`  out  16  data bus to all register `D` inputs; registered.

## Operation
- FSM states:
  - IDLE: arbitration is active.
  - FLUSH: sweeps the registers; both `rdy` are 0.
- IDLE -> FLUSH: when `flush`=1. In that cycle `rdy0`=`rdy1`=0, so a request is never accepted on the same cycle as a flush start.
- FLUSH -> IDLE: after index `NREG-1` is issued. `flush` is ignored while in FLUSH.
- Accept rule: a requester's write is accepted when its `v` and `rdy` are both 1. At most one write is accepted per cycle.
- Arbitration in IDLE (no `flush`):
  - Only `v0`: `rdy0`=1.
  - Only `v1`: `rdy1`=1.
  - Both valid: grant goes to the requester that is not `last_grant`.
  - `last_grant` updates to the winner on every accept.
  - Reset value of `last_grant` is 1, so requester 0 wins the first tie.
- `rdy` is asserted only when the matching `v` is 1. Requesters hold `v`/`a`/`d` stable until accepted.
- Write issue on accept, at the next edge:
  - `wr_data` <= winner's data.
  - `load_vec` <= one-hot(winner's address).
  - Exception: if `ZERO_R0`=1 and the address is 0, `load_vec` <= 0. `wr_data` still updates; the write is still acknowledged.
- Cycles with no accept and not in FLUSH: `load_vec` <= 0 and `wr_data` holds its value.
- Flush sweep:
  - Index counter `idx` starts at 0 on entry.
  - Each FLUSH cycle registers `load_vec` <= one-hot(`idx`) and `wr_data` <= 0, then `idx` increments.
  - Register 0 is included in the sweep regardless of `ZERO_R0`.
  - On `idx`=`NREG-1`, `flush_done` is registered to 1 alongside the last `load_vec`, the FSM returns to IDLE, and `idx` resets to 0.
- `busy` = (state == FLUSH); combinational from the state register.
- Invariant: `load_vec` is zero or one-hot in every cycle.

## Timing
- Reset (`clr`=1 at an edge): state=IDLE, `idx`=0, `last_grant`=1, `load_vec`=0, `wr_data`=0, `flush_done`=0.
  - `rdy0`/`rdy1` are forced to 0 while `clr`=1.
  - A reset mid-flush aborts the sweep immediately; the remaining registers are not written.
- Write latency: accept at edge N produces `load_vec`/`wr_data` valid during cycle N+1, so the register flop captures at edge N+2.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1…
- Flush duration: `flush` sampled at edge F.
  - State is FLUSH for cycles F+1 … F+`NREG`.
  - `load_vec` shows one-hot(0) in cycle F+2 and one-hot(`NREG-1`) in cycle F+`NREG`+1.
  - `flush_done` is high in cycle F+`NREG`+1.
  - `rdy` may reassert in cycle F+`NREG`+1.

## Test plan
- Reset then single write: `v0`=1, `a0`=3, `d0`=16'hBEEF for one cycle -> `rdy0`=1 that cycle; next cycle `load_vec`=8'b0000_1000 and `wr_data`=16'hBEEF; the following cycle `load_vec`=0.
- Contention: `v0` and `v1` held high with `a0`=1, `a1`=2 for 4 cycles -> grant order 0,1,0,1; `load_vec` sequence 0x02,0x04,0x02,0x04, each one cycle after its accept.
- R0 drop: `v1`=1, `a1`=0, `d1`=16'h1234 with `ZERO_R0`=1 -> `rdy1`=1, `load_vec` stays 0, `wr_data`=16'h1234.
- Flush with concurrent request: `flush`=1 and `v0`=1 in the same cycle -> `rdy0`=0; `busy` high for 8 cycles; `load_vec` walks 0x01…0x80 with `wr_data`=0; `flush_done` pulses with 0x80; `v0` is then accepted in the next cycle.
- Reset mid-flush: assert `clr` during the 4th flush cycle -> next cycle `busy`=0, `load_vec`=0, no `flush_done` pulse; a subsequent tie grants requester 0.
- Flush re-trigger: `flush` held high for the whole sweep -> a single sweep runs, then a second sweep starts immediately after `flush_done`, because `flush` is still high in IDLE.
